// File: rtl/reg8_serial_tx.sv
// reg8_serial_tx: parallel-load serial transmitter, start/data(LSB first)/stop framing
module reg8_serial_tx #(
    parameter int   WIDTH    = 8,
    parameter int   DIV      = 4,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    output logic             RDY,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [7:0] DIV_TOP = 8'(DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] div_q, div_d, div_nx;
    logic tick;
    logic so_q, so_d, rdy_q, rdy_d, busy_q, busy_d, done_q, done_d;

    assign tick   = (div_q == DIV_TOP);
    assign div_nx = tick ? 8'd0 : div_q + 8'd1;

    // next state, datapath, and registered outputs derived from the next state
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        case (state_q)
            IDLE: if (EN) begin
                shift_d = D;
                div_d   = 8'd0;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                div_d = div_nx;
                if (tick) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                div_d = div_nx;
                if (tick) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == BIT_LAST) ? STOP : DATA;
                end
            end
            STOP: begin
                div_d = div_nx;
                state_d = tick ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
        so_d   = (state_d == START) ? ~IDLE_LVL : (state_d == DATA) ? shift_d[0] : IDLE_LVL;
        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (div_d == DIV_TOP);
    end

    // state and output registers with synchronous active-low clear
    always_ff @(posedge CK) begin
        if (!CLR) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            div_q   <= 8'd0;
            so_q    <= IDLE_LVL;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            so_q    <= so_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SO   = so_q;
    assign RDY  = rdy_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
endmodule

// File: tb/tb_reg8_serial_tx.sv
// tb_reg8_serial_tx: table-driven and randomized frame checks for three bit-period settings
module tb_reg8_serial_tx;
    logic clk = 1'b0, clr_n = 1'b0, en = 1'b0;
    logic [7:0] d = 8'h00;
    int sel = 0;
    int n_chk = 0, n_fail = 0;
    int divs[3] = '{4, 1, 255};

    logic so4, rdy4, busy4, done4, so1, rdy1, busy1, done1, so255, rdy255, busy255, done255;
    logic so, rdy, busy, done;

    always #5 clk = ~clk;

    reg8_serial_tx #(.WIDTH(8), .DIV(4), .IDLE_LVL(1'b1)) u4 (
        .CK(clk), .CLR(clr_n), .D(d), .EN(en && sel == 0),
        .RDY(rdy4), .SO(so4), .BUSY(busy4), .DONE(done4));
    reg8_serial_tx #(.WIDTH(8), .DIV(1), .IDLE_LVL(1'b1)) u1 (
        .CK(clk), .CLR(clr_n), .D(d), .EN(en && sel == 1),
        .RDY(rdy1), .SO(so1), .BUSY(busy1), .DONE(done1));
    reg8_serial_tx #(.WIDTH(8), .DIV(255), .IDLE_LVL(1'b1)) u255 (
        .CK(clk), .CLR(clr_n), .D(d), .EN(en && sel == 2),
        .RDY(rdy255), .SO(so255), .BUSY(busy255), .DONE(done255));

    assign so   = sel == 0 ? so4   : sel == 1 ? so1   : so255;
    assign rdy  = sel == 0 ? rdy4  : sel == 1 ? rdy1  : rdy255;
    assign busy = sel == 0 ? busy4 : sel == 1 ? busy1 : busy255;
    assign done = sel == 0 ? done4 : sel == 1 ? done1 : done255;

    typedef struct {
        logic [7:0] w;
        int         s;
        logic [9:0] fr;
        int         len;
        int         junk;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // frame model: bit 0 is start, 1..8 data LSB first, 9 is stop
    function automatic logic fbit(input logic [7:0] w, input int idx);
        return idx == 0 ? 1'b0 : idx <= 8 ? w[idx-1] : 1'b1;
    endfunction

    task automatic frame(input string nm, input logic [7:0] w, input int s, input logic [9:0] fr,
                         input int len, input int junk);
        int dv, bad, busy_n, done_n, done_at, rdy_n, c;
        logic [9:0] rec;
        sel = s;
        dv = divs[s];
        bad = 0; busy_n = 0; done_n = 0; done_at = -1; rdy_n = 0; rec = '0;
        c = 0;
        while (!rdy && c < 300) begin @(negedge clk); c++; end
        chk({nm, " rdy_before"}, rdy, 1);
        d = w;
        en = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (so !== fbit(w, (k - 1) / dv)) bad++;
            if ((k - 1) % dv == dv / 2) rec[(k - 1) / dv] = so;
            busy_n += int'(busy);
            rdy_n += int'(rdy);
            if (done) begin done_n++; done_at = k; end
            en = (junk != 0 && k >= 2 && k <= 6);
            d = (junk != 0) ? 8'hFF : 8'($urandom);
        end
        @(negedge clk);
        chk({nm, " so_bad_cycles"}, bad, 0);
        chk({nm, " midbit_frame"}, rec, fr);
        chk({nm, " busy_cycles"}, busy_n, 10 * dv);
        chk({nm, " rdy_in_frame"}, rdy_n, 0);
        chk({nm, " done_count"}, done_n, 1);
        chk({nm, " done_cycle"}, done_at, 10 * dv);
        chk({nm, " rdy_after"}, rdy, 1);
        chk({nm, " busy_after"}, busy, 0);
        busy_n = 0;
        for (int k = 0; k < 12; k++) begin @(negedge clk); busy_n += int'(busy); end
        chk({nm, " no_second_frame"}, busy_n, 0);
    endtask

    vec_t tbl[4];

    initial begin
        int so_bad, rdy_bad, busy_bad, done_bad, rdy_n, done_n;
        logic [7:0] w;
        logic [21:0] stream, exp_stream;
        tbl[0] = '{8'hA5, 0, 10'b1_10100101_0, 40, 0};
        tbl[1] = '{8'h3C, 0, 10'b1_00111100_0, 40, 1};
        tbl[2] = '{8'h5A, 1, 10'b1_01011010_0, 10, 0};
        tbl[3] = '{8'h01, 2, 10'b1_00000001_0, 2550, 0};

        // reset then idle on all three instances
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        so_bad = 0; rdy_bad = 0; busy_bad = 0; done_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            so_bad   += int'(!(so4 && so1 && so255));
            rdy_bad  += int'(!(rdy4 && rdy1 && rdy255));
            busy_bad += int'(busy4 || busy1 || busy255);
            done_bad += int'(done4 || done1 || done255);
        end
        chk("idle so", so_bad, 0);
        chk("idle rdy", rdy_bad, 0);
        chk("idle busy", busy_bad, 0);
        chk("idle done", done_bad, 0);

        for (int i = 0; i < 4; i++)
            frame($sformatf("vec%0d", i), tbl[i].w, tbl[i].s, tbl[i].fr, tbl[i].len, tbl[i].junk);

        for (int i = 0; i < 12; i++) begin
            int s;
            w = 8'($urandom);
            s = int'($urandom_range(0, 1));
            frame($sformatf("rnd%0d", i), w, s, {1'b1, w, 1'b0}, 10 * divs[s], int'($urandom_range(0, 1)));
        end

        // back-to-back at one cycle per bit with EN held high
        sel = 1;
        @(negedge clk);
        d = 8'h00;
        en = 1'b1;
        rdy_n = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            stream[k-1] = so;
            if (k <= 21) rdy_n += int'(rdy);
            if (k == 1) d = 8'hFF;
            if (k == 12) en = 1'b0;
        end
        for (int k = 1; k <= 22; k++)
            exp_stream[k-1] = k <= 10 ? fbit(8'h00, k - 1) : k == 11 ? 1'b1 : k <= 21 ? fbit(8'hFF, k - 12) : 1'b1;
        chk("b2b stream", stream, exp_stream);
        chk("b2b idle_gap", rdy_n, 1);

        // clear in the middle of data bit 3
        sel = 0;
        repeat (3) @(negedge clk);
        d = 8'h81;
        en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            en = 1'b0;
        end
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        chk("abort so", so, 1);
        chk("abort rdy", rdy, 1);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        done_n = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk); done_n += int'(done || busy); end
        chk("abort quiet", done_n, 0);

        frame("after_abort", 8'hC3, 0, 10'b1_11000011_0, 40, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg8_serial_tx.md
Name: reg8_serial_tx

Overview:
- Transmit end for the 8-bit registered datapath: takes a parallel word from a register's Q bus and shifts it out on a single serial line.
- Framing: one start bit, WIDTH data bits LSB first, one stop bit.
- Sits after the REG8/ADD8 datapath. Pairs with a serial-to-parallel receiver that writes words back into a register.
- Uses a valid/ready load handshake and a programmable bit period.

Parameters:
- WIDTH, 8, data word width in bits.
- DIV, 4, clock cycles per serial bit; legal range 1..255.
- IDLE_LVL, 1, line level when idle and during the stop bit. The start bit is the inverse level.

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- CLR  input  1  synchronous active-low reset, sampled on the rising edge of CK.
- D  input  WIDTH  parallel word to transmit.
- EN  input  1  load request (valid); D is captured when EN=1 and RDY=1 at the same edge.
- RDY  output  1  ready to accept a word; high only in IDLE.
- SO  output  1  serial output, registered.
- BUSY  output  1  high from the cycle after load until the end of the stop bit.
- DONE  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset: CLR=0 at a rising edge forces the following, regardless of state (including mid-frame; the frame is aborted and no DONE pulse is emitted):
  - state=IDLE, SO=IDLE_LVL, RDY=1, BUSY=0, DONE=0
  - shift register=0, bit counter=0, divider=0
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - RDY=1, SO=IDLE_LVL, BUSY=0.
  - On EN=1, capture D into the shift register, clear the divider, go to START.
  - RDY drops to 0 the cycle after the load.
- START:
  - SO=~IDLE_LVL for exactly DIV cycles. The first start-bit cycle is the cycle after the load edge.
  - Divider counts 0..DIV-1; on DIV-1, go to DATA with bit counter=0.
- DATA:
  - SO=shift register bit 0, held for DIV cycles per bit.
  - At the end of each bit period, shift right by one (zero fill) and increment the bit counter.
  - After bit WIDTH-1, go to STOP.
- STOP:
  - SO=IDLE_LVL for DIV cycles.
  - DONE=1 during the final cycle of the stop bit, then go to IDLE.
- Frame length: exactly (WIDTH+2)*DIV cycles from the first start-bit cycle to the end of the stop bit.
- Back-to-back: RDY is high in the first cycle back in IDLE. If EN=1 then, the next start bit begins the following cycle, so the minimum gap between frames is one idle cycle.
- EN while not RDY: ignored; no queuing; D is not sampled.
- D changing after the load edge: no effect on the frame in progress.
- DIV=1: each bit lasts one cycle; the divider is always at terminal count.
- Outputs are all registered, with no combinational path from inputs to outputs.
- Divider width is 8 bits; the bit counter width is ceil(log2(WIDTH))+1.

Test Plan:
- Reset then idle: hold CLR=0 for 2 cycles, then CLR=1 with EN=0 for 20 cycles -> SO=1, RDY=1, BUSY=0, DONE=0 throughout.
- Single frame, DIV=4, D=8'hA5, EN pulsed one cycle:
  - SO sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
  - Total 40 cycles; DONE pulses once at cycle 40; RDY returns at cycle 41.
- Back-to-back, DIV=1: D=8'h00 then D=8'hFF, EN held high:
  - Frames 0,00000000,1 and 0,11111111,1.
  - Exactly one idle cycle (SO=1, RDY=1) between them.
- Ignored load: during the frame for 8'h3C, assert EN with D=8'hFF for 5 mid-frame cycles -> the transmitted bits remain 8'h3C; no second frame follows.
- Reset mid-frame: start 8'h81 with DIV=4, drive CLR=0 during data bit 3 -> next cycle SO=1, RDY=1, BUSY=0; no DONE pulse.
- Timing: WIDTH=8, DIV=255 -> BUSY stays high for exactly 2550 cycles; 8'h01 is recovered by sampling SO at mid-bit.
